// File: rtl/wra_pkg.sv
// Shared definitions for the WRA load scheduler: FSM state codes and burst sizing.
// Pure declarations; no logic, no latency, no flow control.
package wra_pkg;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] ARB  = 3'd1;
   localparam logic [2:0] REQ  = 3'd2;
   localparam logic [2:0] XFER = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = IDLE,
      S_ARB  = ARB,
      S_REQ  = REQ,
      S_XFER = XFER,
      S_DONE = DONE
   } state_t;

   localparam int BURST_MAX_DFLT = 16;
   // Width of the memory-port burst field; holds 1..BURST_MAX inclusive.
   localparam int BURST_W = 5;

endpackage

// File: rtl/wra_stream_ctx.sv
// Per-stream address/remaining tracker; load and advance take effect on the next clk.
// No handshake of its own: the scheduler FSM decides when to load or advance.
module wra_stream_ctx
   import wra_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int LEN_W     = 12,
   parameter int BURST_MAX = BURST_MAX_DFLT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [ADDR_W-1:0]  base_i,
   input  logic [LEN_W-1:0]   len_i,
   input  logic               adv_i,
   input  logic [BURST_W-1:0] adv_burst_i,
   output logic [ADDR_W-1:0]  addr_o,
   output logic               pend_o,
   output logic [BURST_W-1:0] burst_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;

   always_comb begin
      addr_d = addr_q;
      rem_d  = rem_q;
      if (load_i) begin
         addr_d = base_i;
         rem_d  = len_i;
      end else if (adv_i) begin
         // Burst never exceeds remaining, so this cannot underflow; address wraps.
         addr_d = addr_q + ADDR_W'(adv_burst_i);
         rem_d  = rem_q - LEN_W'(adv_burst_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         rem_q  <= '0;
      end else begin
         addr_q <= addr_d;
         rem_q  <= rem_d;
      end
   end

   assign addr_o  = addr_q;
   assign pend_o  = (rem_q != '0);
   assign burst_o = (rem_q >= LEN_W'(BURST_MAX)) ? BURST_W'(BURST_MAX) : BURST_W'(rem_q);

endmodule

// File: rtl/wra_load_sched.sv
// Splits data/filter streams into bursts, round-robins them onto one read port, steers beats.
// Enable to mem_req 2 cycles; mem_req holds until mem_gnt; DataPre_done 2 cycles after last beat.
module wra_load_sched
   import wra_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int LEN_W     = 12,
   parameter int BURST_MAX = BURST_MAX_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Data_en,
   input  logic              Filter_en,
   input  logic [ADDR_W-1:0] data_base,
   input  logic [LEN_W-1:0]  data_len,
   input  logic [ADDR_W-1:0] filt_base,
   input  logic [LEN_W-1:0]  filt_len,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [4:0]        mem_burst,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic              mem_rlast,
   output logic              dst_sel,
   output logic              dst_we,
   output logic              DataPre_done,
   output logic              err
);

   state_t             state_q, state_d;
   logic               last_sel_q, last_sel_d;
   logic               sel_q, sel_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [BURST_W-1:0] mem_burst_q, mem_burst_d;
   logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic               start;
   logic               in_xfer;
   logic [BURST_W-1:0] beat_nxt;
   logic               burst_ok;
   logic [ADDR_W-1:0]  d_addr, f_addr;
   logic               d_pend, f_pend;
   logic [BURST_W-1:0] d_burst, f_burst;

   assign start    = (state_q == S_IDLE) && (Data_en || Filter_en);
   assign in_xfer  = (state_q == S_XFER);
   assign beat_nxt = beat_cnt_q + BURST_W'(1);
   assign burst_ok = in_xfer && mem_rvalid && mem_rlast && (beat_nxt == mem_burst_q);

   // A disabled stream loads zero remaining so arbitration simply never picks it.
   wra_stream_ctx #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX)) u_data_ctx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (start),
      .base_i      (data_base),
      .len_i       (Data_en ? data_len : '0),
      .adv_i       (burst_ok && !sel_q),
      .adv_burst_i (mem_burst_q),
      .addr_o      (d_addr),
      .pend_o      (d_pend),
      .burst_o     (d_burst)
   );

   wra_stream_ctx #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX)) u_filt_ctx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (start),
      .base_i      (filt_base),
      .len_i       (Filter_en ? filt_len : '0),
      .adv_i       (burst_ok && sel_q),
      .adv_burst_i (mem_burst_q),
      .addr_o      (f_addr),
      .pend_o      (f_pend),
      .burst_o     (f_burst)
   );

   always_comb begin
      state_d     = state_q;
      last_sel_d  = last_sel_q;
      sel_d       = sel_q;
      mem_addr_d  = mem_addr_q;
      mem_burst_d = mem_burst_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               err_d   = 1'b0;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            if (!d_pend && !f_pend) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               if (d_pend && f_pend) sel_d = ~last_sel_q;
               else                  sel_d = f_pend;
               mem_addr_d  = sel_d ? f_addr  : d_addr;
               mem_burst_d = sel_d ? f_burst : d_burst;
               beat_cnt_d  = '0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) state_d = S_XFER;
         end
         S_XFER: begin
            if (mem_rvalid) begin
               beat_cnt_d = beat_nxt;
               if (burst_ok) begin
                  last_sel_d = sel_q;
                  state_d    = S_ARB;
               end else if (mem_rlast || (beat_nxt == mem_burst_q)) begin
                  // rlast and the beat count disagree: abandon the load.
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!Data_en && !Filter_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_sel_q  <= 1'b1;
         sel_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_burst_q <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_sel_q  <= last_sel_d;
         sel_q       <= sel_d;
         mem_addr_q  <= mem_addr_d;
         mem_burst_q <= mem_burst_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   assign mem_req      = (state_q == S_REQ);
   assign mem_addr     = mem_addr_q;
   assign mem_burst    = mem_burst_q;
   assign dst_sel      = sel_q;
   assign dst_we       = mem_rvalid && in_xfer;
   assign DataPre_done = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_wra_load_sched.sv
// Directed bench for wra_load_sched: a hand-driven memory port serves each expected burst.
module tb_wra_load_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        Data_en, Filter_en;
   logic [15:0] data_base, filt_base;
   logic [11:0] data_len, filt_len;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [4:0]  mem_burst;
   logic        mem_gnt, mem_rvalid, mem_rlast;
   logic        dst_sel, dst_we, DataPre_done, err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wra_load_sched dut (
      .clk          (clk),
      .rst          (rst),
      .Data_en      (Data_en),
      .Filter_en    (Filter_en),
      .data_base    (data_base),
      .data_len     (data_len),
      .filt_base    (filt_base),
      .filt_len     (filt_len),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_burst    (mem_burst),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rlast    (mem_rlast),
      .dst_sel      (dst_sel),
      .dst_we       (dst_we),
      .DataPre_done (DataPre_done),
      .err          (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Wait for the request, check it, optionally stall the grant, then return the beats.
   task automatic serve(input string tag, input logic [15:0] ea, input logic [4:0] eb,
                        input logic es, input int stall, input int early);
      int waited = 0;
      while (!mem_req && waited < 40) begin
         step();
         waited++;
      end
      chk({tag, "_req"},   32'(mem_req),   32'd1);
      chk({tag, "_addr"},  32'(mem_addr),  32'(ea));
      chk({tag, "_burst"}, 32'(mem_burst), 32'(eb));
      for (int i = 0; i < stall; i++) begin
         mem_rvalid = 1'b1;
         #1;
         chk({tag, "_stray_we"}, 32'(dst_we), 32'd0);
         mem_rvalid = 1'b0;
         step();
         chk({tag, "_hold_req"},   32'(mem_req),   32'd1);
         chk({tag, "_hold_addr"},  32'(mem_addr),  32'(ea));
         chk({tag, "_hold_burst"}, 32'(mem_burst), 32'(eb));
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int b = 1; b <= int'(eb); b++) begin
         mem_rvalid = 1'b1;
         mem_rlast  = (b == int'(eb)) || (b == early);
         #1;
         chk({tag, "_we"},  32'(dst_we),  32'd1);
         chk({tag, "_sel"}, 32'(dst_sel), 32'(es));
         step();
         if (b == early) break;
      end
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
   endtask

   // Called in ARB right after the final beat of the final burst.
   task automatic expect_done(input string tag);
      chk({tag, "_done_pre"}, 32'(DataPre_done), 32'd0);
      step();
      chk({tag, "_done_pulse"}, 32'(DataPre_done), 32'd1);
      chk({tag, "_done_noreq"}, 32'(mem_req), 32'd0);
      step();
      chk({tag, "_done_once"}, 32'(DataPre_done), 32'd0);
      Data_en   = 1'b0;
      Filter_en = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      Data_en = 1'b0; Filter_en = 1'b0;
      data_base = '0; data_len = '0; filt_base = '0; filt_len = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
      step();
      step();
      chk("rst_req",   32'(mem_req),      32'd0);
      chk("rst_addr",  32'(mem_addr),     32'd0);
      chk("rst_burst", 32'(mem_burst),    32'd0);
      chk("rst_sel",   32'(dst_sel),      32'd0);
      chk("rst_we",    32'(dst_we),       32'd0);
      chk("rst_done",  32'(DataPre_done), 32'd0);
      chk("rst_err",   32'(err),          32'd0);
      rst = 1'b0;
      step();

      // Both streams, data first after reset: D16 F16 D4 F4.
      data_base = 16'h0200; data_len = 12'd20;
      filt_base = 16'h0800; filt_len = 12'd20;
      Data_en = 1'b1; Filter_en = 1'b1;
      step();
      chk("lat_req_c1", 32'(mem_req), 32'd0);
      step();
      chk("lat_req_c2", 32'(mem_req), 32'd1);
      serve("both_d16", 16'h0200, 5'd16, 1'b0, 0, 0);
      chk("gap_req_arb", 32'(mem_req), 32'd0);
      serve("both_f16", 16'h0800, 5'd16, 1'b1, 0, 0);
      serve("both_d4",  16'h0210, 5'd4,  1'b0, 0, 0);
      serve("both_f4",  16'h0810, 5'd4,  1'b1, 0, 0);
      expect_done("both");
      chk("both_err", 32'(err), 32'd0);

      // Data only; the disabled filter length must be ignored, and so must dropping Data_en.
      data_base = 16'h0100; data_len = 12'd40;
      filt_base = 16'h0999; filt_len = 12'd7;
      Data_en = 1'b1;
      serve("donly_1", 16'h0100, 5'd16, 1'b0, 0, 0);
      Data_en = 1'b0;
      serve("donly_2", 16'h0110, 5'd16, 1'b0, 0, 0);
      serve("donly_3", 16'h0120, 5'd8,  1'b0, 0, 0);
      expect_done("donly");

      // Empty: both lengths zero, no retrigger while Data_en stays high.
      data_len = 12'd0; filt_len = 12'd0;
      Data_en = 1'b1;
      step();
      chk("empty_c1_done", 32'(DataPre_done), 32'd0);
      step();
      chk("empty_c2_done", 32'(DataPre_done), 32'd1);
      chk("empty_c2_req",  32'(mem_req),      32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("empty_hold_done", 32'(DataPre_done), 32'd0);
         chk("empty_hold_req",  32'(mem_req),      32'd0);
      end
      Data_en = 1'b0;
      step();

      // Grant stall of 5 cycles, then an address wrap on the second burst.
      data_base = 16'hFFF8; data_len = 12'd20;
      Data_en = 1'b1;
      serve("stall", 16'hFFF8, 5'd16, 1'b0, 5, 0);
      serve("wrap",  16'h0008, 5'd4,  1'b0, 0, 0);
      expect_done("stall");
      chk("stall_err", 32'(err), 32'd0);

      // Early rlast on beat 3 of 16.
      data_base = 16'h0300; data_len = 12'd32;
      Data_en = 1'b1;
      serve("early", 16'h0300, 5'd16, 1'b0, 0, 3);
      chk("early_done", 32'(DataPre_done), 32'd1);
      chk("early_err",  32'(err),          32'd1);
      step();
      chk("early_done_once", 32'(DataPre_done), 32'd0);
      chk("early_err_held",  32'(err),          32'd1);
      Data_en = 1'b0;
      step();
      chk("early_err_idle", 32'(err), 32'd1);

      // Restart clears err; reset during beat 5; restart reissues the base burst.
      data_base = 16'h0400; data_len = 12'd32;
      Data_en = 1'b1;
      step();
      chk("restart_err_clr", 32'(err), 32'd0);
      step();
      chk("mid_req",  32'(mem_req),  32'd1);
      chk("mid_addr", 32'(mem_addr), 32'h0400);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         mem_rvalid = 1'b1;
         step();
      end
      mem_rvalid = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("mrst_req",   32'(mem_req),      32'd0);
      chk("mrst_addr",  32'(mem_addr),     32'd0);
      chk("mrst_burst", 32'(mem_burst),    32'd0);
      chk("mrst_we",    32'(dst_we),       32'd0);
      chk("mrst_sel",   32'(dst_sel),      32'd0);
      chk("mrst_done",  32'(DataPre_done), 32'd0);
      chk("mrst_err",   32'(err),          32'd0);
      rst = 1'b0;
      mem_rvalid = 1'b0;
      serve("rerun_1", 16'h0400, 5'd16, 1'b0, 0, 0);
      serve("rerun_2", 16'h0410, 5'd16, 1'b0, 0, 0);
      expect_done("rerun");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wra_load_sched.md
# wra_load_sched

Load scheduler placed between the top-level control FSM and the shared external-memory read port of DMA_WRA. When a layer enters its load phase, the block splits the input-data stream and the filter stream into bounded bursts and arbitrates them round-robin onto the single memory port. It steers returning beats to the correct on-chip buffer and reports completion as a one-cycle `DataPre_done` pulse.

## Interface
Parameters:
- `ADDR_W`, 16: word-address width of the memory port and base registers.
- `LEN_W`, 12: width of the stream length fields, in words.
- `BURST_MAX`, 16: maximum beats per burst; power of two, at least 2.

Ports (one clock `clk`; reset `rst` is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `Data_en`  in  1  level; input-data stream requested.
- `Filter_en`  in  1  level; filter stream requested.
- `data_base`  in  ADDR_W  data start address; sampled at start.
- `data_len`  in  LEN_W  data length in words; sampled at start; 0 skips the stream.
- `filt_base`  in  ADDR_W  filter start address; sampled at start.
- `filt_len`  in  LEN_W  filter length in words; sampled at start; 0 skips the stream.
- `mem_req`  out  1  burst request.
- `mem_addr`  out  ADDR_W  burst start address.
- `mem_burst`  out  5  beats in this burst (1..BURST_MAX).
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rlast`  in  1  last beat of the burst.
- `dst_sel`  out  1  0 = data buffer, 1 = filter buffer; valid with `mem_rvalid`.
- `dst_we`  out  1  buffer write enable; equals `mem_rvalid` while in XFER.
- `DataPre_done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky; set on a burst-length mismatch; cleared only by `rst` or at the next start.

## Operation
- States are IDLE, ARB, REQ, XFER, DONE.
- **IDLE.** When `Data_en | Filter_en` is high:
  - Latch the base and length of each enabled stream. A disabled stream gets remaining = 0.
  - Clear `err` and go to ARB.
- **ARB.**
  - If both remaining counts are 0, go to DONE.
  - Otherwise pick a stream. If both are pending, pick the one not served last; `last_sel` resets to 1, so data goes first.
  - Compute the burst length as min(remaining, BURST_MAX).
  - Go to REQ.
- **REQ.**
  - Hold `mem_req`=1 with stable `mem_addr` and `mem_burst` until `mem_gnt` is high.
  - On grant, go to XFER.
- **XFER.**
  - Count `mem_rvalid` beats.
  - On a beat with `mem_rlast`=1 and count equal to `mem_burst`:
    - remaining -= burst; address += burst (wraps modulo 2^ADDR_W).
    - Update `last_sel`, then go to ARB.
  - Mismatch: `mem_rlast` before the final count, or the final counted beat without `mem_rlast`. Set `err` and go to DONE.
- **DONE.**
  - Pulse `DataPre_done` for exactly one cycle on entry.
  - Stay in DONE until `Data_en` and `Filter_en` are both low, then return to IDLE. This prevents a retrigger while the enables are still high.
- **Enables deasserted mid-operation.** Ignored. The in-flight burst and all remaining bursts complete normally.
- **Remaining counts.** LEN_W wide; they never underflow because burst ≤ remaining.

## Timing
- Reset values: all outputs are 0, state = IDLE, `last_sel` = 1.
- All outputs are registered or decoded from state only, with no combinational path from inputs. The one exception is `dst_we` = `mem_rvalid` & (state == XFER).
- Latency:
  - Enable high to `mem_req` high is 2 cycles (IDLE→ARB→REQ).
  - Final `mem_rlast` beat to next `mem_req` is 2 cycles.
  - Final `mem_rlast` beat of the last burst to `DataPre_done` is 2 cycles (XFER→ARB→DONE).
  - Both lengths 0: `DataPre_done` pulses 2 cycles after the enable.
- `mem_gnt` may arrive in the same cycle `mem_req` rises. `mem_rvalid` may arrive in the cycle after the grant.
- Beats arriving in ARB, REQ or DONE are ignored and do not produce `dst_we`.
- Reset asserted mid-burst returns the block to IDLE immediately. Outstanding memory beats are the memory side's responsibility.

## Structure
- Shared package `wra_pkg`: the state encoding (3-bit localparams IDLE=0 … DONE=4) and the `BURST_MAX` default.
- One sub-module, `wra_stream_ctx`, instantiated once per stream. It holds the base/remaining registers and provides the load, advance and burst-length computation.
- The top level contains the FSM, the round-robin pointer and the beat counter.

## Test plan
- **Data only.** `data_len`=40, `filt_len`=0, base 0x100. Expect 3 bursts: (0x100, 16), (0x110, 16), (0x120, 8). Expect 40 `dst_we` with `dst_sel`=0, then one `DataPre_done` pulse.
- **Both streams.** `data_len`=20, `filt_len`=20. Expect burst order D16, F16, D4, F4 with correct `dst_sel` on every beat.
- **Empty.** Both lengths 0 with `Data_en`=1. Expect `DataPre_done` 2 cycles later, no `mem_req`, and no second pulse while `Data_en` stays high.
- **Grant stall.** Hold `mem_gnt` low for 5 cycles. `mem_addr` and `mem_burst` stay stable; the transfer completes after the grant.
- **Early rlast.** `mem_rlast` on beat 3 of a 16-beat burst. Expect `err`=1 and `DataPre_done` pulsed; the next start clears `err`.
- **Reset mid-XFER.** Assert `rst` during beat 5. All outputs are 0 in the same cycle; a restart reissues the first burst at the base address.
